path_metric_bank: RTL and testbench
===================================

Name: path_metric_bank

Overview:
- Parametrised path-metric register bank for the Viterbi add-compare-select loop; generalises the fixed 4-state, 5-bit metric register.
- Registers NUM_STATES metrics of MW bits each, on a valid qualifier.
- Applies threshold normalisation so metrics never overflow.
- Reports the registered minimum metric and its state index to traceback, and loads known initial metrics at frame start.

Parameters:
- NUM_STATES, 4, number of trellis states (power of 2, >= 2).
- MW, 5, metric width in bits (>= 3).
- NORM_THRESH, 16, normalisation subtrahend; must be 2^(MW-1).
- INIT_BIAS, 15, initial metric for states 1..NUM_STATES-1 (must be < 2^MW).
- CW, 8, width of normalisation event counter.
- IW, 2, index width, equal to log2(NUM_STATES).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  synchronous frame-start; loads initial metrics.
- in_valid  input  1  m_in carries new ACS results this cycle.
- m_in  input  NUM_STATES*MW  new metrics; state i at bits [i*MW +: MW].
- m_out  output  NUM_STATES*MW  registered metrics, same packing.
- out_valid  output  1  m_out updated from m_in on the previous edge.
- min_idx  output  IW  index of smallest registered metric.
- min_metric  output  MW  value of smallest registered metric.
- norm_pulse  output  1  one-cycle pulse; the last update was normalised.
- norm_count  output  CW  saturating count of normalisation events since reset/start.

Behaviour:
- Reset (async, immediate), outputs:
  - m_out state 0 = 0; states 1..N-1 = INIT_BIAS.
  - out_valid = 0, norm_pulse = 0, norm_count = 0.
  - min_idx = 0, min_metric = 0.
- start=1 at an edge: same load as reset. Has priority over in_valid; that cycle's m_in is discarded and out_valid = 0 next cycle.
- in_valid=1, start=0 at an edge:
  - Compute mn = min over all m_in (unsigned).
  - If mn >= NORM_THRESH: store m_in[i] - NORM_THRESH for every i (equivalent to clearing the MSB), and set norm_pulse=1.
  - Else store m_in unchanged and set norm_pulse=0.
  - Set out_valid=1.
  - min_idx/min_metric = index/value of the minimum of the stored values. Ties resolve to the lowest index.
  - norm_count increments on a normalised update and saturates at 2^CW-1 (no wrap).
- in_valid=0, start=0: m_out, min_idx, min_metric and norm_count hold; out_valid=0; norm_pulse=0.
- Latency: exactly one clock from in_valid to m_out/out_valid/min_*/norm_pulse.
- No internal arithmetic overflow: inputs are MW bits and subtraction occurs only when all inputs >= NORM_THRESH.
- Min search is a balanced comparator tree computed on the post-normalisation values before the register; the registered outputs are mutually consistent in the same cycle.
- Reset asserted mid-stream: all state returns to reset values within the same cycle; the first edge after deassertion behaves per the rules above.

Test Plan:
- Reset -> m_out = {s0=0, s1=15, s2=15, s3=15}, out_valid=0, min_idx=0, min_metric=0, norm_count=0.
- in_valid with m_in {3,7,2,9} (s0..s3) -> next cycle m_out={3,7,2,9}, out_valid=1, min_idx=2, min_metric=2, norm_pulse=0.
- in_valid with {18,20,16,31} -> m_out={2,4,0,15}, norm_pulse=1 for one cycle, min_idx=2, min_metric=0, norm_count=1; 255 more normalising updates -> norm_count holds at 255.
- Tie {5,5,9,5} -> min_idx=0, min_metric=5. Then in_valid=0 for 3 cycles -> outputs hold, out_valid=0.
- start and in_valid together with m_in {1,1,1,1} -> initial metrics loaded, out_valid=0, norm_count=0.
- Reset pulsed asynchronously between edges during a stream -> outputs go to reset values immediately; next valid update after release is correct.

Source files
------------

// File: rtl/path_metric_bank.sv
// Path-metric register bank for the Viterbi ACS loop: registers NUM_STATES metrics,
// applies threshold normalisation and reports the registered minimum and its index.
module path_metric_bank #(
  parameter int NUM_STATES  = 4,
  parameter int MW          = 5,
  parameter int NORM_THRESH = 16,
  parameter int INIT_BIAS   = 15,
  parameter int CW          = 8,
  parameter int IW          = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [NUM_STATES*MW-1:0] m_in,
  output logic [NUM_STATES*MW-1:0] m_out,
  output logic                     out_valid,
  output logic [IW-1:0]            min_idx,
  output logic [MW-1:0]            min_metric,
  output logic                     norm_pulse,
  output logic [CW-1:0]            norm_count
);

  localparam logic [MW-1:0] THRESH_W = MW'(NORM_THRESH);
  localparam logic [MW-1:0] BIAS_W   = MW'(INIT_BIAS);

  function automatic logic [NUM_STATES*MW-1:0] init_vec();
    logic [NUM_STATES*MW-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < NUM_STATES; i++) v[i*MW +: MW] = BIAS_W;
    return v;
  endfunction

  localparam logic [NUM_STATES*MW-1:0] INIT_VEC = init_vec();

  logic [NUM_STATES*MW-1:0] metrics_q, metrics_d;
  logic                     valid_q;
  logic [IW-1:0]            min_idx_q, min_idx_d;
  logic [MW-1:0]            min_val_q, min_val_d;
  logic                     pulse_q;
  logic                     norm_d;
  logic [CW-1:0]            count_q;

  logic [MW-1:0] tv [NUM_STATES];
  logic [IW-1:0] ti [NUM_STATES];

  // Threshold is 2^(MW-1), so "min >= threshold" is the same as "every input >= threshold".
  always_comb begin
    int unsigned s;
    int unsigned j;
    norm_d    = 1'b1;
    metrics_d = m_in;
    s         = 0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_STATES; i++)
      if (m_in[i*MW +: MW] < THRESH_W) norm_d = 1'b0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      metrics_d[i*MW +: MW] = norm_d ? (m_in[i*MW +: MW] - THRESH_W) : m_in[i*MW +: MW];
      tv[i] = metrics_d[i*MW +: MW];
      ti[i] = IW'(i);
    end
    // Balanced tree, reduced in place; strict < keeps the lower index on ties.
    for (int unsigned lvl = 0; lvl < IW; lvl++) begin
      s = 1 << lvl;
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        if (i % (2 * s) == 0) begin
          j = (i + s) % NUM_STATES;
          if (tv[j] < tv[i]) begin
            tv[i] = tv[j];
            ti[i] = ti[j];
          end
        end
      end
    end
    min_val_d = tv[0];
    min_idx_d = ti[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      metrics_q <= INIT_VEC;
      valid_q   <= 1'b0;
      min_idx_q <= '0;
      min_val_q <= '0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else if (start) begin
      metrics_q <= INIT_VEC;
      valid_q   <= 1'b0;
      min_idx_q <= '0;
      min_val_q <= '0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else if (in_valid) begin
      metrics_q <= metrics_d;
      valid_q   <= 1'b1;
      min_idx_q <= min_idx_d;
      min_val_q <= min_val_d;
      pulse_q   <= norm_d;
      if (norm_d && (count_q != '1)) count_q <= count_q + 1'b1;
    end else begin
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end
  end

  assign m_out      = metrics_q;
  assign out_valid  = valid_q;
  assign min_idx    = min_idx_q;
  assign min_metric = min_val_q;
  assign norm_pulse = pulse_q;
  assign norm_count = count_q;

endmodule

// File: tb/tb_path_metric_bank.sv
// Directed table-driven bench for path_metric_bank (default 4 states, 5-bit metrics).
module tb_path_metric_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [19:0] m_in;
  logic [19:0] m_out;
  logic        out_valid;
  logic [1:0]  min_idx;
  logic [4:0]  min_metric;
  logic        norm_pulse;
  logic [7:0]  norm_count;

  int n_vec = 0;
  int n_bad = 0;

  path_metric_bank #(
    .NUM_STATES (4),
    .MW         (5),
    .NORM_THRESH(16),
    .INIT_BIAS  (15),
    .CW         (8),
    .IW         (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .m_in      (m_in),
    .m_out     (m_out),
    .out_valid (out_valid),
    .min_idx   (min_idx),
    .min_metric(min_metric),
    .norm_pulse(norm_pulse),
    .norm_count(norm_count)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " m_out"},      32'(m_out), 32'(pk(0, 15, 15, 15)));
    chk({tag, " out_valid"},  32'(out_valid), 32'd0);
    chk({tag, " norm_pulse"}, 32'(norm_pulse), 32'd0);
    chk({tag, " norm_count"}, 32'(norm_count), 32'd0);
    chk({tag, " min_idx"},    32'(min_idx), 32'd0);
    chk({tag, " min_metric"}, 32'(min_metric), 32'd0);
  endtask

  typedef struct {
    logic [19:0] vin;
    logic [19:0] vexp;
    int          idx;
    int          mn;
    int          pulse;
    int          cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{pk(3, 7, 2, 9),     pk(3, 7, 2, 9),    2, 2,  0, 0};
    tbl[1] = '{pk(18, 20, 16, 31), pk(2, 4, 0, 15),   2, 0,  1, 1};
    tbl[2] = '{pk(5, 5, 9, 5),     pk(5, 5, 9, 5),    0, 5,  0, 1};
    tbl[3] = '{pk(16, 16, 16, 16), pk(0, 0, 0, 0),    0, 0,  1, 2};
    tbl[4] = '{pk(31, 17, 30, 16), pk(15, 1, 14, 0),  3, 0,  1, 3};
    tbl[5] = '{pk(15, 31, 31, 31), pk(15, 31, 31, 31), 0, 15, 0, 3};
    tbl[6] = '{pk(20, 9, 9, 30),   pk(20, 9, 9, 30),  1, 9,  0, 3};
    tbl[7] = '{pk(31, 31, 31, 31), pk(15, 15, 15, 15), 0, 15, 1, 4};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    m_in     = '0;
    #1;
    chk_reset_state("reset");
    #13;
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      m_in     = tbl[k].vin;
      tick();
      chk($sformatf("v%0d m_out", k),      32'(m_out), 32'(tbl[k].vexp));
      chk($sformatf("v%0d out_valid", k),  32'(out_valid), 32'd1);
      chk($sformatf("v%0d min_idx", k),    32'(min_idx), 32'(tbl[k].idx));
      chk($sformatf("v%0d min_metric", k), 32'(min_metric), 32'(tbl[k].mn));
      chk($sformatf("v%0d norm_pulse", k), 32'(norm_pulse), 32'(tbl[k].pulse));
      chk($sformatf("v%0d norm_count", k), 32'(norm_count), 32'(tbl[k].cnt));
    end

    // Idle cycles: everything holds except out_valid/norm_pulse.
    in_valid = 1'b0;
    m_in     = pk(1, 2, 3, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold m_out",      32'(m_out), 32'(pk(15, 15, 15, 15)));
      chk("hold out_valid",  32'(out_valid), 32'd0);
      chk("hold norm_pulse", 32'(norm_pulse), 32'd0);
      chk("hold min_metric", 32'(min_metric), 32'd15);
      chk("hold norm_count", 32'(norm_count), 32'd4);
    end

    // Saturation: count starts at 4, 260 more normalising updates.
    in_valid = 1'b1;
    m_in     = pk(19, 18, 17, 16);
    for (int k = 0; k < 260; k++) begin
      tick();
      if (k == 250) chk("sat count 255", 32'(norm_count), 32'd255);
    end
    chk("sat norm_count", 32'(norm_count), 32'd255);
    chk("sat norm_pulse", 32'(norm_pulse), 32'd1);
    chk("sat m_out",      32'(m_out), 32'(pk(3, 2, 1, 0)));
    chk("sat min_idx",    32'(min_idx), 32'd3);

    // Asynchronous reset between edges while a stream is running.
    m_in = pk(25, 24, 23, 22);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    #2;
    reset    = 1'b0;
    m_in     = pk(3, 7, 2, 9);
    tick();
    chk("post-reset m_out",      32'(m_out), 32'(pk(3, 7, 2, 9)));
    chk("post-reset out_valid",  32'(out_valid), 32'd1);
    chk("post-reset min_idx",    32'(min_idx), 32'd2);
    chk("post-reset norm_count", 32'(norm_count), 32'd0);

    // Start wins over in_valid; make count non-zero first.
    m_in = pk(30, 16, 17, 18);
    tick();
    chk("pre-start norm_count", 32'(norm_count), 32'd1);
    chk("pre-start min_idx",    32'(min_idx), 32'd1);
    start = 1'b1;
    m_in  = pk(1, 1, 1, 1);
    tick();
    chk_reset_state("start");
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("after-start m_out", 32'(m_out), 32'(pk(0, 15, 15, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
